// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine coin interface: FSM states,
// error codes, coin values and the coin-select enum.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_INSERT,
        ST_GAP,
        ST_WAIT_VEND,
        ST_THANK,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_BAD_PRICE = 2'd1,
        ERR_NO_FUNDS  = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKEL,
        COIN_DIME,
        COIN_QUARTER
    } coin_t;

    localparam logic [7:0] NICKEL_CENTS  = 8'd5;
    localparam logic [7:0] DIME_CENTS    = 8'd10;
    localparam logic [7:0] QUARTER_CENTS = 8'd25;

    function automatic logic [7:0] coin_value(input coin_t coin);
        case (coin)
            COIN_NICKEL:  coin_value = NICKEL_CENTS;
            COIN_DIME:    coin_value = DIME_CENTS;
            COIN_QUARTER: coin_value = QUARTER_CENTS;
            default:      coin_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Priority coin picker: biggest coin that does not overshoot the remainder,
// falling back to any available coin (smallest first) to finish the payment.
module coin_select
    import vend_pkg::*;
(
    input  logic [7:0] rem,
    input  logic       nickel_ok,
    input  logic       dime_ok,
    input  logic       quarter_ok,
    output coin_t      coin
);

    always_comb begin
        coin = COIN_NONE;
        if (quarter_ok && rem >= QUARTER_CENTS)
            coin = COIN_QUARTER;
        else if (dime_ok && rem >= DIME_CENTS)
            coin = COIN_DIME;
        else if (nickel_ok)
            coin = COIN_NICKEL;
        else if (dime_ok)
            coin = COIN_DIME;
        else if (quarter_ok)
            coin = COIN_QUARTER;
    end

endmodule

// File: rtl/coin_payer.sv
// Customer-side coin driver: pays a price from a wallet, waits for the vend,
// totals returned change and acknowledges with thanks_in.
//
// state      | meaning
// IDLE       | waiting for start
// CHECK      | validate price, decide paid / next coin / out of funds
// INSERT     | one-cycle coin pulse toward the machine
// GAP        | GAP_CYCLES quiet cycles between coins
// WAIT_VEND  | fully paid, waiting up to TIMEOUT+1 cycles for candy_out
// THANK      | one-cycle thanks_in pulse
// FIN        | one-cycle done pulse, err valid
module coin_payer
    import vend_pkg::*;
#(
    parameter int GAP_CYCLES = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] price,
    input  logic [3:0] nickel_avail,
    input  logic [3:0] dime_avail,
    input  logic [3:0] quarter_avail,
    input  logic       candy_out,
    input  logic       nickel_out,
    input  logic [1:0] dime_out,
    output logic       nickel_in,
    output logic       dime_in,
    output logic       quarter_in,
    output logic       thanks_in,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [7:0] paid,
    output logic [7:0] change
);

    state_t     state, state_nxt;
    err_t       err_q, err_nxt;
    coin_t      sel, pick;
    logic [6:0] price_q;
    logic [3:0] nickel_cnt, dime_cnt, quarter_cnt;
    logic [7:0] tmr, tmr_nxt;
    logic       thanks_nxt, done_nxt;
    logic       accept, price_bad, in_window;
    logic [7:0] rem, ret_cents;
    logic [8:0] chg_sum;

    assign accept    = (state == ST_IDLE) && start;
    assign price_bad = (price_q == 7'd0) || ((price_q % 7'd5) != 7'd0);
    assign rem       = {1'b0, price_q} - paid;
    assign err       = err_q;

    coin_select u_coin_select (
        .rem        (rem),
        .nickel_ok  (nickel_cnt != 4'd0),
        .dime_ok    (dime_cnt != 4'd0),
        .quarter_ok (quarter_cnt != 4'd0),
        .coin       (sel)
    );

    // Change window opens with the first coin; CHECK before any coin has paid == 0.
    assign in_window = (state inside {ST_INSERT, ST_GAP, ST_WAIT_VEND, ST_THANK})
                    || ((state == ST_CHECK) && (paid != 8'd0));
    assign ret_cents = (nickel_out ? NICKEL_CENTS : 8'd0) + ({6'd0, dime_out} * DIME_CENTS);
    assign chg_sum   = {1'b0, change} + {1'b0, ret_cents};

    always_comb begin
        state_nxt  = state;
        err_nxt    = err_q;
        tmr_nxt    = tmr;
        pick       = COIN_NONE;
        thanks_nxt = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CHECK;
                    err_nxt   = ERR_OK;
                end
            end
            ST_CHECK: begin
                if (price_bad) begin
                    state_nxt = ST_FIN;
                    err_nxt   = ERR_BAD_PRICE;
                    done_nxt  = 1'b1;
                end else if (paid >= {1'b0, price_q}) begin
                    state_nxt = ST_WAIT_VEND;
                    tmr_nxt   = 8'(TIMEOUT);
                end else if (sel == COIN_NONE) begin
                    state_nxt = ST_FIN;
                    err_nxt   = ERR_NO_FUNDS;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_INSERT;
                    pick      = sel;
                end
            end
            ST_INSERT: begin
                state_nxt = ST_GAP;
                tmr_nxt   = 8'(GAP_CYCLES - 1);
            end
            ST_GAP: begin
                if (tmr == 8'd0)
                    state_nxt = ST_CHECK;
                else
                    tmr_nxt = tmr - 8'd1;
            end
            ST_WAIT_VEND: begin
                if (candy_out) begin
                    state_nxt  = ST_THANK;
                    thanks_nxt = 1'b1;
                end else if (tmr == 8'd0) begin
                    state_nxt = ST_FIN;
                    err_nxt   = ERR_TIMEOUT;
                    done_nxt  = 1'b1;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            ST_THANK: begin
                state_nxt = ST_FIN;
                done_nxt  = 1'b1;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            err_q       <= ERR_OK;
            tmr         <= 8'd0;
            price_q     <= 7'd0;
            nickel_cnt  <= 4'd0;
            dime_cnt    <= 4'd0;
            quarter_cnt <= 4'd0;
            paid        <= 8'd0;
            change      <= 8'd0;
            nickel_in   <= 1'b0;
            dime_in     <= 1'b0;
            quarter_in  <= 1'b0;
            thanks_in   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state      <= state_nxt;
            err_q      <= err_nxt;
            tmr        <= tmr_nxt;
            thanks_in  <= thanks_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt != ST_IDLE);
            nickel_in  <= (pick == COIN_NICKEL);
            dime_in    <= (pick == COIN_DIME);
            quarter_in <= (pick == COIN_QUARTER);
            if (accept) begin
                price_q     <= price;
                nickel_cnt  <= nickel_avail;
                dime_cnt    <= dime_avail;
                quarter_cnt <= quarter_avail;
                paid        <= 8'd0;
                change      <= 8'd0;
            end else begin
                case (pick)
                    COIN_NICKEL:  nickel_cnt  <= nickel_cnt - 4'd1;
                    COIN_DIME:    dime_cnt    <= dime_cnt - 4'd1;
                    COIN_QUARTER: quarter_cnt <= quarter_cnt - 4'd1;
                    default: ;
                endcase
                if (pick != COIN_NONE)
                    paid <= paid + coin_value(pick);
                if (in_window)
                    change <= chg_sum[8] ? 8'hFF : chg_sum[7:0];
            end
        end
    end

endmodule

// File: tb/tb_coin_payer.sv
// Directed bench for coin_payer: a vector table of whole purchases driven
// against a small vending-machine model, plus hand-written corner sequences.
module tb_coin_payer;

    logic       clk = 1'b0;
    logic       rst, start, candy_out, nickel_out;
    logic [6:0] price;
    logic [3:0] nickel_avail, dime_avail, quarter_avail;
    logic [1:0] dime_out;
    logic       nickel_in, dime_in, quarter_in, thanks_in, busy, done;
    logic [1:0] err;
    logic [7:0] paid, change;

    int n_tests = 0;
    int n_fail  = 0;

    coin_payer #(.GAP_CYCLES(3), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .price         (price),
        .nickel_avail  (nickel_avail),
        .dime_avail    (dime_avail),
        .quarter_avail (quarter_avail),
        .candy_out     (candy_out),
        .nickel_out    (nickel_out),
        .dime_out      (dime_out),
        .nickel_in     (nickel_in),
        .dime_in       (dime_in),
        .quarter_in    (quarter_in),
        .thanks_in     (thanks_in),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .paid          (paid),
        .change        (change)
    );

    always #5 clk = ~clk;

    // k counts negedges after the edge that samples start; the machine model
    // vends 6 cycles after the coin that covers the price (inside WAIT_VEND).
    typedef struct packed {
        int price, na, nd, nq, vend, ret_n, ret_d, restart_k;
        int e_err, e_paid, e_change, e_n, e_d, e_q, e_thanks, e_first, e_last, e_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int total = 0, trig = 0, done_k = 0, thanks_n = 0, first = 0, last = 0;
        int cn = 0, cd = 0, cq = 0, r_err = -1, r_paid = -1, r_change = -1;
        bit coin;
        @(negedge clk);
        price         = 7'(v.price);
        nickel_avail  = 4'(v.na);
        dime_avail    = 4'(v.nd);
        quarter_avail = 4'(v.nq);
        start         = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            coin = nickel_in | dime_in | quarter_in;
            if (nickel_in)  begin cn++; total += 5;  end
            if (dime_in)    begin cd++; total += 10; end
            if (quarter_in) begin cq++; total += 25; end
            if (coin) begin
                if (first == 0) first = k;
                last = k;
                if (v.vend != 0 && trig == 0 && total >= v.price) trig = k + 6;
            end
            if (thanks_in) thanks_n++;
            start = (k == v.restart_k);
            if (start) begin
                price        = 7'd5;
                nickel_avail = 4'd15;
            end
            candy_out  = (k == trig);
            nickel_out = (k == trig) && (v.ret_n != 0);
            dime_out   = (k == trig) ? 2'(v.ret_d) : 2'd0;
            if (done) begin
                done_k   = k;
                r_err    = int'(err);
                r_paid   = int'(paid);
                r_change = int'(change);
                break;
            end
        end
        start = 1'b0; candy_out = 1'b0; nickel_out = 1'b0; dime_out = 2'd0;
        check({tag, "_done_latency"}, done_k, v.e_lat);
        check({tag, "_err"}, r_err, v.e_err);
        check({tag, "_paid"}, r_paid, v.e_paid);
        check({tag, "_change"}, r_change, v.e_change);
        check({tag, "_nickels"}, cn, v.e_n);
        check({tag, "_dimes"}, cd, v.e_d);
        check({tag, "_quarters"}, cq, v.e_q);
        check({tag, "_thanks"}, thanks_n, v.e_thanks);
        check({tag, "_first_coin"}, first, v.e_first);
        check({tag, "_last_coin"}, last, v.e_last);
        @(negedge clk);
        check({tag, "_busy_done_after"}, int'({busy, done}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n, k_done;
        rst = 1'b1; start = 1'b0; candy_out = 1'b0; nickel_out = 1'b0; dime_out = 2'd0;
        price = 7'd0; nickel_avail = 4'd0; dime_avail = 4'd0; quarter_avail = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_coins", int'({nickel_in, dime_in, quarter_in}), 0);
        check("reset_flags", int'({thanks_in, busy, done}), 0);
        check("reset_err", int'(err), 0);
        check("reset_paid", int'(paid), 0);
        check("reset_change", int'(change), 0);
        rst = 1'b0;

        //          price na nd nq vend rn rd rs  err paid chg  n  d  q th f  l  lat
        vecs[0] = '{15,   0, 2, 0, 1,   1, 0, 4,  0,  20,  5,   0, 2, 0, 1, 2, 7, 15};
        vecs[1] = '{15,   0, 0, 1, 1,   0, 1, 0,  0,  25,  10,  0, 0, 1, 1, 2, 2, 10};
        vecs[2] = '{30,   1, 1, 0, 0,   0, 0, 0,  2,  15,  0,   1, 1, 0, 0, 2, 7, 12};
        vecs[3] = '{17,   2, 2, 2, 0,   0, 0, 0,  1,  0,   0,   0, 0, 0, 0, 0, 0, 2};
        vecs[4] = '{0,    2, 2, 2, 0,   0, 0, 0,  1,  0,   0,   0, 0, 0, 0, 0, 0, 2};
        vecs[5] = '{5,    1, 0, 0, 0,   0, 0, 0,  3,  5,   0,   1, 0, 0, 0, 2, 2, 24};
        vecs[6] = '{15,   1, 1, 1, 1,   0, 0, 0,  0,  15,  0,   1, 1, 0, 1, 2, 7, 15};
        vecs[7] = '{40,   0, 0, 2, 1,   0, 1, 0,  0,  50,  10,  0, 0, 2, 1, 2, 7, 15};
        vecs[8] = '{5,    0, 1, 0, 1,   1, 0, 0,  0,  10,  5,   0, 1, 0, 1, 2, 2, 10};

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Returns and candy while idle must not touch change, err or thanks.
        done_n = 0;
        candy_out = 1'b1; nickel_out = 1'b1; dime_out = 2'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (thanks_in || busy) done_n++;
        end
        candy_out = 1'b0; nickel_out = 1'b0; dime_out = 2'd0;
        @(negedge clk);
        check("idle_returns_change", int'(change), vecs[8].e_change);
        check("idle_err_held", int'(err), vecs[8].e_err);
        check("idle_no_activity", done_n, 0);

        // Reset while in GAP after the first dime.
        @(negedge clk);
        price = 7'd15; nickel_avail = 4'd0; dime_avail = 4'd2; quarter_avail = 4'd0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("rstgap_first_dime", int'(dime_in), 1);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rstgap_coins", int'({nickel_in, dime_in, quarter_in}), 0);
        check("rstgap_flags", int'({thanks_in, busy, done}), 0);
        check("rstgap_paid", int'(paid), 0);
        check("rstgap_err_change", int'({err, change}), 0);
        done_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("rstgap_stays_idle", done_n, 0);
        run_vec(vecs[0], "rstgap_rerun");

        // Continuous 3-dime returns: window opens at the first INSERT, saturates at 255.
        @(negedge clk);
        price = 7'd5; nickel_avail = 4'd1; dime_avail = 4'd0; quarter_avail = 4'd0;
        dime_out = 2'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k_done = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) check("sat_change_before_window", int'(change), 0);
            if (k == 3) check("sat_change_first_cycle", int'(change), 30);
            if (done) begin
                k_done = k;
                check("sat_err", int'(err), 3);
                check("sat_change_final", int'(change), 255);
                break;
            end
        end
        dime_out = 2'd0;
        check("sat_done_latency", k_done, 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
